// File: rtl/user_event_gen.sv
// Purpose : turns five raw buttons into 3-bit game event codes and queues them in a show-ahead FIFO.
// Latency : a clean input edge reaches user_event_ready_o DEBOUNCE_CYCLES+4 cycles later (2 sync, debounce, pending, write).
// Backpres: a full FIFO holds events in per-button pending flags; a repeat event on a pending button merges and pulses overflow_o.
//
// Ports:
//   clk_i, srst_i                 clock, synchronous active-high reset
//   btn_*_i                       raw asynchronous active-high buttons
//   user_event_o                  head-of-FIFO event code, valid while user_event_ready_o=1
//   user_event_ready_o            FIFO not empty
//   user_event_rd_req_i           pop request, honoured only while ready
//   overflow_o                    one-cycle pulse when an event merged into a pending one
module user_event_gen #(
   parameter int DEBOUNCE_CYCLES      = 500000,
   parameter int REPEAT_DELAY_CYCLES  = 15000000,
   parameter int REPEAT_PERIOD_CYCLES = 5000000,
   parameter int FIFO_DEPTH           = 4
) (
   input  logic       clk_i,
   input  logic       srst_i,
   input  logic       btn_left_i,
   input  logic       btn_right_i,
   input  logic       btn_down_i,
   input  logic       btn_rotate_i,
   input  logic       btn_new_game_i,
   output logic [2:0] user_event_o,
   output logic       user_event_ready_o,
   input  logic       user_event_rd_req_i,
   output logic       overflow_o
);

   // Event codes, matching the values in defs.vh.
   localparam logic [2:0] EV_NONE     = 3'd0;
   localparam logic [2:0] EV_LEFT     = 3'd1;
   localparam logic [2:0] EV_RIGHT    = 3'd2;
   localparam logic [2:0] EV_DOWN     = 3'd3;
   localparam logic [2:0] EV_ROTATE   = 3'd4;
   localparam logic [2:0] EV_NEW_GAME = 3'd5;

   // Button indices inside the per-button vectors.
   localparam int NB    = 5;
   localparam int B_LEFT  = 0;
   localparam int B_RIGHT = 1;
   localparam int B_DOWN  = 2;
   localparam int B_ROT   = 3;
   localparam int B_NEW   = 4;

   // Only LEFT, RIGHT and DOWN autorepeat.
   localparam logic [NB-1:0] REPEATS = 5'b00111;

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
   localparam int RP_W   = $clog2(RP_MAX + 1);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RP_W-1:0]  RP_DELAY   = RP_W'(REPEAT_DELAY_CYCLES);
   localparam logic [RP_W-1:0]  RP_PERIOD  = RP_W'(REPEAT_PERIOD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_DEPTH  = CNT_W'(FIFO_DEPTH);

   logic [NB-1:0]   btn_raw;
   logic [NB-1:0]   sync1, sync2;
   logic [NB-1:0]   stable, stable_q;
   logic [DB_W-1:0] db_cnt [NB];
   logic [RP_W-1:0] rp_cnt [NB];
   logic [NB-1:0]   rp_first;
   logic [NB-1:0]   rp_hit;
   logic [NB-1:0]   ev;
   logic [NB-1:0]   pend;
   logic [NB-1:0]   sel;
   logic [NB-1:0]   clr;
   logic [2:0]      sel_code;

   logic [2:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             ready;
   logic             pop;
   logic             wr_en;

   assign btn_raw = {btn_new_game_i, btn_rotate_i, btn_down_i, btn_right_i, btn_left_i};

   // Synchroniser, debounce and repeat counters.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         sync1    <= '0;
         sync2    <= '0;
         stable   <= '0;
         stable_q <= '0;
         rp_first <= '0;
         for (int i = 0; i < NB; i++) begin
            db_cnt[i] <= '0;
            rp_cnt[i] <= '0;
         end
      end else begin
         sync1    <= btn_raw;
         sync2    <= sync1;
         stable_q <= stable;
         for (int i = 0; i < NB; i++) begin
            // Any agreeing cycle restarts the stability window.
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end

            // rp_cnt equals the number of cycles since the rise (or since the
            // last repeat, restarting at 1), so a hit lands exactly on the
            // delay/period boundary.
            if (!REPEATS[i] || !stable[i]) begin
               rp_cnt[i]   <= '0;
               rp_first[i] <= 1'b0;
            end else if (rp_hit[i]) begin
               rp_cnt[i]   <= RP_W'(1);
               rp_first[i] <= 1'b1;
            end else begin
               rp_cnt[i] <= rp_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Event sources: debounced rise plus autorepeat hits.
   always_comb begin
      rp_hit = '0;
      for (int i = 0; i < NB; i++) begin
         rp_hit[i] = REPEATS[i] & stable[i] &
                     (rp_cnt[i] == (rp_first[i] ? RP_PERIOD : RP_DELAY));
      end
      ev = (stable & ~stable_q) | rp_hit;
   end

   // Arbiter: fixed priority NEW_GAME > ROTATE > DOWN > LEFT > RIGHT.
   always_comb begin
      sel      = '0;
      sel_code = EV_NONE;
      if (pend[B_NEW]) begin
         sel[B_NEW] = 1'b1;
         sel_code   = EV_NEW_GAME;
      end else if (pend[B_ROT]) begin
         sel[B_ROT] = 1'b1;
         sel_code   = EV_ROTATE;
      end else if (pend[B_DOWN]) begin
         sel[B_DOWN] = 1'b1;
         sel_code    = EV_DOWN;
      end else if (pend[B_LEFT]) begin
         sel[B_LEFT] = 1'b1;
         sel_code    = EV_LEFT;
      end else if (pend[B_RIGHT]) begin
         sel[B_RIGHT] = 1'b1;
         sel_code     = EV_RIGHT;
      end
   end

   assign ready = (count != '0);
   assign pop   = user_event_rd_req_i & ready;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign wr_en = (|pend) & ((count < CNT_DEPTH) | pop);
   assign clr   = wr_en ? sel : '0;

   // Pending flags and merge detection.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         pend       <= '0;
         overflow_o <= 1'b0;
      end else begin
         pend       <= (pend & ~clr) | ev;
         overflow_o <= |(ev & pend & ~clr);
      end
   end

   // Show-ahead FIFO storage and pointers.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= EV_NONE;
         end
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= sel_code;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign user_event_ready_o = ready;
   assign user_event_o       = ready ? mem[rd_ptr] : EV_NONE;

endmodule

// File: tb/tb_user_event_gen.sv
// Directed bench for user_event_gen with a scoreboard of expected pops.
module tb_user_event_gen;

   localparam int D   = 4;
   localparam int RD  = 20;
   localparam int RP  = 8;
   localparam int DEP = 4;

   localparam logic [2:0] EV_LEFT     = 3'd1;
   localparam logic [2:0] EV_RIGHT    = 3'd2;
   localparam logic [2:0] EV_DOWN     = 3'd3;
   localparam logic [2:0] EV_ROTATE   = 3'd4;
   localparam logic [2:0] EV_NEW_GAME = 3'd5;

   logic       clk;
   logic       srst;
   logic       btn_left, btn_right, btn_down, btn_rotate, btn_new_game;
   logic [2:0] user_event;
   logic       ready;
   logic       rd_req;
   logic       overflow;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int ovf_cnt = 0;
   logic [2:0] exp_q[$];
   int pop_cyc[$];

   user_event_gen #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY_CYCLES(RD),
      .REPEAT_PERIOD_CYCLES(RP),
      .FIFO_DEPTH(DEP)
   ) dut (
      .clk_i(clk),
      .srst_i(srst),
      .btn_left_i(btn_left),
      .btn_right_i(btn_right),
      .btn_down_i(btn_down),
      .btn_rotate_i(btn_rotate),
      .btn_new_game_i(btn_new_game),
      .user_event_o(user_event),
      .user_event_ready_o(ready),
      .user_event_rd_req_i(rd_req),
      .overflow_o(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard side: every pop the DUT performs is compared to the oldest expectation.
   always @(negedge clk) begin
      if (ready === 1'b1 && rd_req === 1'b1) begin
         pop_cyc.push_back(cyc);
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL pop_unexpected: observed code %0d, expected no pop", user_event);
         end
         if (exp_q.size() != 0) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            checks++;
            assert (user_event === e) else begin
               errors++;
               $error("FAIL pop_code: observed %0d expected %0d", user_event, e);
            end
         end
      end
      if (overflow === 1'b1) ovf_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int runs[8];
      int bad;
      int lvl;
      int total;
      int idx;
      int r;
      int ovf_base;

      runs = '{1, 3, 2, 3, 1, 2, 3, 2};
      srst = 1'b1;
      btn_left = 0; btn_right = 0; btn_down = 0; btn_rotate = 0; btn_new_game = 0;
      rd_req = 0;
      tick(3);
      chk("reset_ready", ready, 0);
      chk("reset_event", user_event, 0);
      chk("reset_overflow", overflow, 0);
      srst = 1'b0;
      tick(2);

      // 1. Clean press: held below the repeat delay so only the press event exists.
      exp_q.push_back(EV_LEFT);
      btn_left = 1;
      tick(7);
      chk("t1_ready_at_7", ready, 0);
      tick(1);
      chk("t1_ready_at_8", ready, 1);
      chk("t1_head", user_event, EV_LEFT);
      tick(8);
      btn_left = 0;
      tick(30);
      chk("t1_still_one", ready, 1);
      rd_req = 1;
      tick(1);
      rd_req = 0;
      chk("t1_ready_after_pop", ready, 0);
      tick(5);
      chk("t1_empty", ready, 0);
      chk("t1_sb_drained", exp_q.size(), 0);

      // 2. Bounce: runs of 1..3 cycles never satisfy the debounce window.
      bad = 0; lvl = 1; total = 0; idx = 0;
      while (total < 40) begin
         r = runs[idx % 8];
         if (total + r > 40) r = 40 - total;
         for (int k = 0; k < r; k++) begin
            btn_right = lvl[0];
            tick(1);
            if (ready !== 1'b0 || overflow !== 1'b0) bad++;
         end
         total += r;
         lvl = 1 - lvl;
         idx++;
      end
      btn_right = 0;
      for (int k = 0; k < 12; k++) begin
         tick(1);
         if (ready !== 1'b0 || overflow !== 1'b0) bad++;
      end
      chk("t2_bounce_quiet", bad, 0);

      // 3. Autorepeat: DOWN stable for 50 cycles -> press + repeats at +20,+28,+36,+44.
      rd_req = 1;
      repeat (5) exp_q.push_back(EV_DOWN);
      pop_cyc.delete();
      btn_down = 1;
      tick(50);
      btn_down = 0;
      tick(40);
      chk("t3_down_pops", pop_cyc.size(), 5);
      if (pop_cyc.size() >= 5) begin
         chk("t3_gap0", pop_cyc[1] - pop_cyc[0], RD);
         chk("t3_gap1", pop_cyc[2] - pop_cyc[1], RP);
         chk("t3_gap2", pop_cyc[3] - pop_cyc[2], RP);
         chk("t3_gap3", pop_cyc[4] - pop_cyc[3], RP);
      end
      exp_q.push_back(EV_ROTATE);
      pop_cyc.delete();
      btn_rotate = 1;
      tick(50);
      btn_rotate = 0;
      tick(30);
      chk("t3_rotate_pops", pop_cyc.size(), 1);
      rd_req = 0;
      chk("t3_no_overflow", ovf_cnt, 0);

      // 4. Simultaneous rise: NEW_GAME written first, LEFT on the very next cycle.
      exp_q.push_back(EV_NEW_GAME);
      exp_q.push_back(EV_LEFT);
      btn_new_game = 1;
      btn_left = 1;
      tick(8);
      chk("t4_ready", ready, 1);
      chk("t4_head_ng", user_event, EV_NEW_GAME);
      rd_req = 1;
      tick(1);
      chk("t4_ready_second", ready, 1);
      chk("t4_head_left", user_event, EV_LEFT);
      tick(1);
      rd_req = 0;
      chk("t4_empty", ready, 0);
      btn_new_game = 0;
      btn_left = 0;
      tick(20);
      chk("t4_sb_drained", exp_q.size(), 0);

      // 5. Fill with four events, then merge a second NEW_GAME while full.
      exp_q.push_back(EV_ROTATE);  btn_rotate = 1; tick(8); btn_rotate = 0; tick(10);
      exp_q.push_back(EV_DOWN);    btn_down   = 1; tick(8); btn_down   = 0; tick(10);
      exp_q.push_back(EV_LEFT);    btn_left   = 1; tick(8); btn_left   = 0; tick(10);
      exp_q.push_back(EV_RIGHT);   btn_right  = 1; tick(8); btn_right  = 0; tick(10);
      chk("t5_full_ready", ready, 1);
      ovf_base = ovf_cnt;
      exp_q.push_back(EV_NEW_GAME);
      btn_new_game = 1; tick(8); btn_new_game = 0; tick(10);
      chk("t5_no_ovf_first", ovf_cnt - ovf_base, 0);
      btn_new_game = 1; tick(8); btn_new_game = 0; tick(10);
      chk("t5_one_ovf", ovf_cnt - ovf_base, 1);
      chk("t5_head_unchanged", user_event, EV_ROTATE);
      rd_req = 1;
      tick(5);
      rd_req = 0;
      chk("t5_empty", ready, 0);
      chk("t5_sb_drained", exp_q.size(), 0);

      // 6. Reset with two queued events while LEFT is held through reset.
      exp_q.push_back(EV_ROTATE);  btn_rotate = 1; tick(8); btn_rotate = 0; tick(10);
      exp_q.push_back(EV_DOWN);    btn_down   = 1; tick(8); btn_down   = 0; tick(10);
      chk("t6_queued", ready, 1);
      ovf_base = ovf_cnt;
      btn_left = 1;
      tick(3);
      srst = 1;
      exp_q.delete();
      tick(1);
      srst = 0;
      chk("t6_ready_after_reset", ready, 0);
      exp_q.push_back(EV_LEFT);
      tick(7);
      chk("t6_ready_at_7", ready, 0);
      tick(1);
      chk("t6_ready_at_8", ready, 1);
      chk("t6_head_left", user_event, EV_LEFT);
      tick(2);
      btn_left = 0;
      tick(20);
      rd_req = 1;
      tick(1);
      rd_req = 0;
      chk("t6_single_event", ready, 0);
      chk("t6_sb_drained", exp_q.size(), 0);
      chk("t6_no_overflow", ovf_cnt - ovf_base, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
